// File: rtl/output_arbiter.sv
// Round-robin owner arbiter for the shared output pin bank, with a dead gap between owners.
// Optional hold limit per grant: define OUTPUT_ARBITER_HOLD_LIMIT_EN.
module output_arbiter #(
    parameter int unsigned N          = 5,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned HOLD_MAX   = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 expired
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("output_arbiter: N must be 2..8");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("output_arbiter: GAP_CYCLES must be 1..15");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("output_arbiter: HOLD_MAX must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_t;

    state_t        state_q;
    logic [OW-1:0] last_q;
    logic [GW-1:0] gap_cnt_q;

    logic          win_found;
    logic [OW-1:0] win_idx;
    logic [OW-1:0] idx;

    // First set request after the last owner, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = OW'((int'(last_q) + i) % N);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

`ifdef OUTPUT_ARBITER_HOLD_LIMIT_EN
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold_cnt_q;
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            grant     <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            last_q    <= OW'(N - 1);
            gap_cnt_q <= '0;
`ifdef OUTPUT_ARBITER_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
            expired    <= 1'b0;
`endif
        end else begin
`ifdef OUTPUT_ARBITER_HOLD_LIMIT_EN
            expired <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q <= StGrant;
                        grant   <= N'(1) << win_idx;
                        owner   <= win_idx;
                        busy    <= 1'b1;
`ifdef OUTPUT_ARBITER_HOLD_LIMIT_EN
                        hold_cnt_q <= '0;
`endif
                    end
                end
                StGrant: begin
                    if (!req[owner]) begin
                        state_q   <= StGap;
                        last_q    <= owner;
                        grant     <= '0;
                        busy      <= 1'b0;
                        gap_cnt_q <= '0;
`ifdef OUTPUT_ARBITER_HOLD_LIMIT_EN
                    end else if (hold_cnt_q == HW'(HOLD_MAX - 1)) begin
                        // Revoked owner goes to the back of the rotation via last_q.
                        state_q   <= StGap;
                        last_q    <= owner;
                        grant     <= '0;
                        busy      <= 1'b0;
                        gap_cnt_q <= '0;
                        expired   <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        gap_cnt_q <= '0;
                        if (win_found) begin
                            state_q <= StGrant;
                            grant   <= N'(1) << win_idx;
                            owner   <= win_idx;
                            busy    <= 1'b1;
`ifdef OUTPUT_ARBITER_HOLD_LIMIT_EN
                            hold_cnt_q <= '0;
`endif
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
